stego_decoder: RTL

Standalone extraction engine for the steganography datapath: it recovers the hidden message that the embedding pixel processor wrote into the image. It pulls stego pixels from the pixel input FIFO three at a time and evaluates the base-27 extraction function f = (p0 + 3·p1 + 9·p2) mod 27 to recover one 4-bit nibble per triplet. It packs nibble pairs into bytes, interprets the first two bytes as a big-endian message length, and writes exactly that many payload bytes to the message output FIFO.

---
 rtl/stego_pkg.sv | 27 ++
 rtl/emd27_digit.sv | 27 ++
 rtl/stego_decoder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/stego_pkg.sv
// Shared steganography constants and types for the decoder and embedding processor.
package stego_pkg;

  localparam int unsigned STEGO_BASE       = 27;
  localparam int unsigned STEGO_GROUP      = 3;
  localparam int unsigned STEGO_NIBBLE_MAX = 15;
  localparam int unsigned STEGO_LEN_BYTES  = 2;

  typedef enum logic [3:0] {
    StIdle,
    StRdReq,
    StRdCap,
    StCalc,
    StMod,
    StPack,
    StWrite,
    StCheck,
    StDone
  } dec_state_e;

  typedef enum logic [1:0] {
    PhHeader,
    PhPayload,
    PhCheck
  } phase_e;

endpackage

// File: rtl/emd27_digit.sv
// Two-stage registered triplet-to-digit calculator: sum = p0 + 3*p1 + 9*p2, then sum mod 27.
module emd27_digit
  import stego_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       calc_en,
  input  logic       mod_en,
  input  logic [7:0] p0,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  output logic [4:0] digit
);

  logic [11:0] sum_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
      digit <= '0;
    end else begin
      if (calc_en) sum_q <= {4'd0, p0} + 12'd3 * {4'd0, p1} + 12'd9 * {4'd0, p2};
      if (mod_en)  digit <= 5'(sum_q % 12'(STEGO_BASE));
    end
  end

endmodule

// File: rtl/stego_decoder.sv
// Stego extraction engine: pixel triplets -> base-27 nibbles -> length header + payload bytes.
// STEGO_DEC_CHECKSUM_EN adds a trailing XOR checksum byte that drives chk_err.
module stego_decoder
  import stego_pkg::*;
#(
  parameter int unsigned FF_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [FF_DATA_WIDTH-1:0] ff_pixel_data,
  input  logic                     ff_pixel_empty,
  output logic                     ff_pixel_rd,
  input  logic                     ff_full,
  output logic [FF_DATA_WIDTH-1:0] ff_data,
  output logic                     ff_wr,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              len_out,
  output logic                     digit_err,
  output logic                     chk_err
);

`ifdef STEGO_DEC_CHECKSUM_EN
  localparam dec_state_e AfterPayload = StRdReq;
`else
  localparam dec_state_e AfterPayload = StDone;
`endif

  dec_state_e state;
  phase_e     phase;
  logic [1:0] idx;
  logic       nib_flag;
  logic       hdr_cnt;
  logic [7:0] pix0, pix1, pix2;
  logic [7:0] byte_q;
  logic [15:0] byte_cnt;
  logic [4:0] digit;
  logic [7:0] full_byte;
  logic [15:0] cnt_next;

  assign full_byte = {byte_q[7:4], digit[3:0]};
  assign cnt_next  = byte_cnt + 16'd1;

  // Read strobe is combinational so the FIFO's next-cycle data lands exactly in RD_CAP.
  assign ff_pixel_rd = rst_n && (state == StRdReq) && !ff_pixel_empty;

  emd27_digit u_digit (
    .clk     (clk),
    .rst_n   (rst_n),
    .calc_en (state == StCalc),
    .mod_en  (state == StMod),
    .p0      (pix0),
    .p1      (pix1),
    .p2      (pix2),
    .digit   (digit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      phase     <= PhHeader;
      idx       <= '0;
      nib_flag  <= 1'b0;
      hdr_cnt   <= 1'b0;
      pix0      <= '0;
      pix1      <= '0;
      pix2      <= '0;
      byte_q    <= '0;
      byte_cnt  <= '0;
      ff_wr     <= 1'b0;
      ff_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      len_out   <= '0;
      digit_err <= 1'b0;
    end else begin
      ff_wr <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        StIdle: if (start) begin
          idx       <= '0;
          nib_flag  <= 1'b0;
          hdr_cnt   <= 1'b0;
          byte_cnt  <= '0;
          len_out   <= '0;
          digit_err <= 1'b0;
          phase     <= PhHeader;
          busy      <= 1'b1;
          state     <= StRdReq;
        end
        StRdReq: if (!ff_pixel_empty) state <= StRdCap;
        StRdCap: begin
          if (idx == 2'd0)      pix0 <= ff_pixel_data[7:0];
          else if (idx == 2'd1) pix1 <= ff_pixel_data[7:0];
          else                  pix2 <= ff_pixel_data[7:0];
          if (idx == 2'(STEGO_GROUP - 1)) begin
            idx   <= '0;
            state <= StCalc;
          end else begin
            idx   <= idx + 2'd1;
            state <= StRdReq;
          end
        end
        StCalc: state <= StMod;
        StMod:  state <= StPack;
        StPack: begin
          if (digit > 5'(STEGO_NIBBLE_MAX)) digit_err <= 1'b1;
          if (!nib_flag) begin
            byte_q[7:4] <= digit[3:0];
            nib_flag    <= 1'b1;
            state       <= StRdReq;
          end else begin
            nib_flag <= 1'b0;
            byte_q   <= full_byte;
            unique case (phase)
              PhHeader: begin
                if (!hdr_cnt) begin
                  len_out[15:8] <= full_byte;
                  hdr_cnt       <= 1'b1;
                  state         <= StRdReq;
                end else begin
                  len_out[7:0] <= full_byte;
                  if ({len_out[15:8], full_byte} == 16'd0) begin
                    phase <= PhCheck;
                    state <= AfterPayload;
                  end else begin
                    phase <= PhPayload;
                    state <= StRdReq;
                  end
                end
              end
              PhPayload: state <= StWrite;
              default:   state <= StCheck;
            endcase
          end
        end
        StWrite: if (!ff_full) begin
          ff_wr    <= 1'b1;
          ff_data  <= FF_DATA_WIDTH'(byte_q);
          byte_cnt <= cnt_next;
          if (cnt_next == len_out) begin
            phase <= PhCheck;
            state <= AfterPayload;
          end else begin
            state <= StRdReq;
          end
        end
        StCheck: state <= StDone;
        StDone: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef STEGO_DEC_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xor_q   <= '0;
      chk_err <= 1'b0;
    end else if (state == StIdle && start) begin
      xor_q   <= '0;
      chk_err <= 1'b0;
    end else if (state == StWrite && !ff_full) begin
      xor_q <= xor_q ^ byte_q;
    end else if (state == StCheck && byte_q != xor_q) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
